dual_wb_regfile: RTL and testbench
==================================

Name: dual_wb_regfile

Overview:
- Receiving end of the dual-issue writeback interface: consumes the two-lane WB-to-RF bus and commits up to two GPR writes plus HI/LO updates per cycle.
- Holds 32x32 GPRs ($0 hardwired zero) and the HI/LO pair.
- Serves four combinational GPR read ports to ID (two per issue lane) and the HI/LO read ports.
- Optional same-cycle write-to-read bypass.

Parameters:
- WRITE_BYPASS, 1, when 1 a read of an address being written this cycle returns the incoming write data; when 0 it returns the stored value.
- HILO_WD, 66, per-lane HI/LO bus width, packed as {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}.
- LANE_WD, 104, per-lane bus width = HILO_WD + 1 + 5 + 32.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- wb_to_rf_bus  in  2*LANE_WD (208)  bits [207:104] = lane 2, [103:0] = lane 1. Each lane is {hilo_bus[65:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}, MSB first.
- raddr1, raddr2  in  5  lane-1 rs/rt read addresses.
- raddr3, raddr4  in  5  lane-2 rs/rt read addresses.
- rdata1..rdata4  out  32  read data for raddr1..raddr4.
- hi_rdata  out  32  current HI, bypassed if WRITE_BYPASS.
- lo_rdata  out  32  current LO, bypassed if WRITE_BYPASS.

Behaviour:
- Reset:
  - On a posedge with rst=1, all 32 GPRs, HI and LO are cleared to 0.
  - All writes arriving that cycle are discarded.
  - While rst=1, bypass is suppressed; outputs reflect stored contents.
  - From the cycle after the first reset edge, every rdata, hi_rdata and lo_rdata reads 0.
  - Reset asserted in the same cycle as valid writes: reset wins, no write lands.
- GPR write:
  - On posedge with rst=0, a lane with rf_we=1 and rf_waddr!=0 writes rf_wdata into that register.
  - Write latency: visible through the stored array on the next cycle.
  - Writes to $0 are dropped; any read of address 0 always returns 0, including under bypass.
- Dual write, same address: lane 2 is program-order younger and wins. Lane-1 data for that address is discarded.
- Dual write, different addresses: both commit in the same cycle.
- HI/LO write:
  - hi_we and lo_we act independently per lane.
  - If both lanes assert the same enable, lane 2 data wins.
  - Lane 1 may write HI while lane 2 writes LO in the same cycle; both commit.
- Reads:
  - Purely combinational from raddr and stored state, zero-cycle latency.
  - Read ports are fully independent; duplicate addresses across ports are allowed.
- Bypass (WRITE_BYPASS=1, rst=0), per read port, in priority order:
  1. Address 0 returns 0.
  2. Lane 2 writing the same address returns lane-2 rf_wdata.
  3. Lane 1 writing the same address returns lane-1 rf_wdata.
  4. Otherwise returns the stored value.
  - hi_rdata and lo_rdata use the same lane-2 > lane-1 > stored priority on their respective enables.
- WRITE_BYPASS=0: reads return stored values only; a same-cycle write becomes visible the following cycle.
- A stalled or bubbled WB presents an all-zero bus: no enables set, nothing changes. The block has no stall input of its own.
- There are no other state machines. Storage is flip-flop based (no RAM inference requirement) so that four read ports are possible.

Test Plan:
- Reset: preload r5=0x1234_5678 and HI=0xAAAA_0000, then assert rst for 1 cycle -> next cycle rdata (raddr=5)=0, hi_rdata=0, lo_rdata=0.
- Dual write, distinct addresses: lane1 r3=0x0000_0011, lane2 r4=0x0000_0022 in one cycle -> next cycle raddr1=3 gives 0x11 and raddr3=4 gives 0x22.
- Same-address conflict: lane1 r7=0x1111_1111, lane2 r7=0x2222_2222 in one cycle -> r7 reads 0x2222_2222 on all four ports afterwards.
- $0 protection: lane2 writes r0=0xFFFF_FFFF -> raddr=0 reads 0 in the same cycle and the next, with WRITE_BYPASS=1 and 0.
- Bypass: WRITE_BYPASS=1, lane1 r9=0xDEAD_BEEF with raddr2=9 in the same cycle -> rdata2=0xDEAD_BEEF immediately. Same stimulus with WRITE_BYPASS=0 -> rdata2 shows the old value, then 0xDEAD_BEEF next cycle.
- HI/LO split: lane1 hi_we=1 HI=0x5, lane2 lo_we=1 LO=0x6 -> next cycle hi_rdata=5, lo_rdata=6. Then both lanes hi_we=1 with HI=0x7 and 0x8 -> hi_rdata=8.

Source files
------------

// File: rtl/dual_wb_regfile.sv
// Dual-issue writeback register file: 32x32 GPRs plus HI/LO,
// two write lanes, four GPR read ports, optional write bypass.
module dual_wb_regfile #(
  parameter int WRITE_BYPASS = 1,
  parameter int HILO_WD      = 66,
  parameter int LANE_WD      = 104
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*LANE_WD-1:0]   wb_to_rf_bus,
  input  logic [4:0]             raddr1,
  input  logic [4:0]             raddr2,
  input  logic [4:0]             raddr3,
  input  logic [4:0]             raddr4,
  output logic [31:0]            rdata1,
  output logic [31:0]            rdata2,
  output logic [31:0]            rdata3,
  output logic [31:0]            rdata4,
  output logic [31:0]            hi_rdata,
  output logic [31:0]            lo_rdata
);

  logic [LANE_WD-1:0] l1_bus;
  logic [LANE_WD-1:0] l2_bus;
  logic [HILO_WD-1:0] l1_hilo;
  logic [HILO_WD-1:0] l2_hilo;

  logic        l1_we;
  logic [4:0]  l1_waddr;
  logic [31:0] l1_wdata;
  logic        l1_hi_we;
  logic        l1_lo_we;
  logic [31:0] l1_hi;
  logic [31:0] l1_lo;

  logic        l2_we;
  logic [4:0]  l2_waddr;
  logic [31:0] l2_wdata;
  logic        l2_hi_we;
  logic        l2_lo_we;
  logic [31:0] l2_hi;
  logic [31:0] l2_lo;

  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] hi_q;
  logic [31:0] hi_d;
  logic [31:0] lo_q;
  logic [31:0] lo_d;

  logic byp_en;

  assign l1_bus  = wb_to_rf_bus[LANE_WD-1:0];
  assign l2_bus  = wb_to_rf_bus[2*LANE_WD-1:LANE_WD];
  assign l1_hilo = l1_bus[LANE_WD-1 -: HILO_WD];
  assign l2_hilo = l2_bus[LANE_WD-1 -: HILO_WD];

  assign l1_wdata = l1_bus[31:0];
  assign l1_waddr = l1_bus[36:32];
  assign l1_we    = l1_bus[37];
  assign l1_lo    = l1_hilo[31:0];
  assign l1_hi    = l1_hilo[63:32];
  assign l1_lo_we = l1_hilo[64];
  assign l1_hi_we = l1_hilo[65];

  assign l2_wdata = l2_bus[31:0];
  assign l2_waddr = l2_bus[36:32];
  assign l2_we    = l2_bus[37];
  assign l2_lo    = l2_hilo[31:0];
  assign l2_hi    = l2_hilo[63:32];
  assign l2_lo_we = l2_hilo[64];
  assign l2_hi_we = l2_hilo[65];

  assign byp_en = (WRITE_BYPASS != 0) && !rst;

  // Lane 2 is younger in program order, so it is applied last.
  always_comb begin
    for (int i = 0; i < 32; i++) gpr_d[i] = gpr_q[i];
    hi_d = hi_q;
    lo_d = lo_q;
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_d[i] = '0;
      hi_d = '0;
      lo_d = '0;
    end else begin
      if (l1_we) gpr_d[l1_waddr] = l1_wdata;
      if (l2_we) gpr_d[l2_waddr] = l2_wdata;
      if (l1_hi_we) hi_d = l1_hi;
      if (l2_hi_we) hi_d = l2_hi;
      if (l1_lo_we) lo_d = l1_lo;
      if (l2_lo_we) lo_d = l2_lo;
      gpr_d[0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) gpr_q[i] <= gpr_d[i];
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    logic [31:0] r;
    r = gpr_q[a];
    if (byp_en && l1_we && l1_waddr == a) r = l1_wdata;
    if (byp_en && l2_we && l2_waddr == a) r = l2_wdata;
    if (a == 5'd0) r = '0;
    return r;
  endfunction

  always_comb begin
    rdata1 = rd_port(raddr1);
    rdata2 = rd_port(raddr2);
    rdata3 = rd_port(raddr3);
    rdata4 = rd_port(raddr4);
    hi_rdata = hi_q;
    lo_rdata = lo_q;
    if (byp_en && l1_hi_we) hi_rdata = l1_hi;
    if (byp_en && l2_hi_we) hi_rdata = l2_hi;
    if (byp_en && l1_lo_we) lo_rdata = l1_lo;
    if (byp_en && l2_lo_we) lo_rdata = l2_lo;
  end

endmodule

// File: tb/tb_dual_wb_regfile.sv
// Directed bench for dual_wb_regfile, run with and
// without write bypass side by side.
module tb_dual_wb_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic [207:0] bus;
  logic [4:0]   ra1, ra2, ra3, ra4;

  logic [31:0] b_rd1, b_rd2, b_rd3, b_rd4, b_hi, b_lo;
  logic [31:0] n_rd1, n_rd2, n_rd3, n_rd4, n_hi, n_lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dual_wb_regfile #(.WRITE_BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
    .raddr1(ra1), .raddr2(ra2), .raddr3(ra3), .raddr4(ra4),
    .rdata1(b_rd1), .rdata2(b_rd2), .rdata3(b_rd3), .rdata4(b_rd4),
    .hi_rdata(b_hi), .lo_rdata(b_lo)
  );

  dual_wb_regfile #(.WRITE_BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
    .raddr1(ra1), .raddr2(ra2), .raddr3(ra3), .raddr4(ra4),
    .rdata1(n_rd1), .rdata2(n_rd2), .rdata3(n_rd3), .rdata4(n_rd4),
    .hi_rdata(n_hi), .lo_rdata(n_lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] lane(
    input logic hwe, input logic lwe,
    input logic [31:0] h, input logic [31:0] l,
    input logic we, input logic [4:0] a, input logic [31:0] d);
    return {hwe, lwe, h, l, we, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [103:0] NOP = '0;

  initial begin
    rst = 1'b1;
    bus = '0;
    ra1 = 5'd5; ra2 = 5'd0; ra3 = 5'd0; ra4 = 5'd0;
    tick();
    chk("rst_rd1_b", b_rd1, 32'h0);
    chk("rst_hi_b", b_hi, 32'h0);
    chk("rst_lo_n", n_lo, 32'h0);

    // preload r5 and HI
    rst = 1'b0;
    bus = {NOP, lane(1'b1, 1'b0, 32'hAAAA_0000, 32'h0,
                     1'b1, 5'd5, 32'h1234_5678)};
    tick();
    bus = '0;
    #1;
    chk("pre_r5_n", n_rd1, 32'h1234_5678);
    chk("pre_hi_n", n_hi, 32'hAAAA_0000);

    // reset with a concurrent write: reset wins, no bypass
    rst = 1'b1;
    ra2 = 5'd6;
    bus = {lane(1'b0, 1'b1, 32'h0, 32'h77, 1'b1, 5'd6, 32'h99), NOP};
    #1;
    chk("rst_nobyp_rd2", b_rd2, 32'h0);
    chk("rst_nobyp_r5", b_rd1, 32'h1234_5678);
    chk("rst_nobyp_hi", b_hi, 32'hAAAA_0000);
    tick();
    rst = 1'b0;
    bus = '0;
    #1;
    chk("rst2_r5_b", b_rd1, 32'h0);
    chk("rst2_r5_n", n_rd1, 32'h0);
    chk("rst2_hi_b", b_hi, 32'h0);
    chk("rst2_lo_b", b_lo, 32'h0);
    chk("rst2_r6_n", n_rd2, 32'h0);

    // dual write, distinct addresses
    bus = {lane(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 32'h22),
           lane(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h11)};
    tick();
    bus = '0;
    ra1 = 5'd3; ra3 = 5'd4;
    #1;
    chk("dual_r3_n", n_rd1, 32'h11);
    chk("dual_r4_n", n_rd3, 32'h22);
    chk("dual_r3_b", b_rd1, 32'h11);
    chk("dual_r4_b", b_rd3, 32'h22);

    // same-address conflict on r7
    ra1 = 5'd7; ra2 = 5'd7; ra3 = 5'd7; ra4 = 5'd7;
    bus = {lane(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h2222_2222),
           lane(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h1111_1111)};
    #1;
    chk("conf_byp_b", b_rd1, 32'h2222_2222);
    chk("conf_old_n", n_rd1, 32'h0);
    tick();
    bus = '0;
    #1;
    chk("conf_rd1_b", b_rd1, 32'h2222_2222);
    chk("conf_rd2_b", b_rd2, 32'h2222_2222);
    chk("conf_rd3_b", b_rd3, 32'h2222_2222);
    chk("conf_rd4_b", b_rd4, 32'h2222_2222);
    chk("conf_rd1_n", n_rd1, 32'h2222_2222);
    chk("conf_rd4_n", n_rd4, 32'h2222_2222);

    // $0 protection
    ra1 = 5'd0;
    bus = {lane(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF),
           NOP};
    #1;
    chk("r0_same_b", b_rd1, 32'h0);
    chk("r0_same_n", n_rd1, 32'h0);
    tick();
    bus = '0;
    #1;
    chk("r0_next_b", b_rd1, 32'h0);
    chk("r0_next_n", n_rd1, 32'h0);

    // same-cycle bypass on r9
    ra2 = 5'd9;
    bus = {NOP,
           lane(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 32'hDEAD_BEEF)};
    #1;
    chk("byp_r9_b", b_rd2, 32'hDEAD_BEEF);
    chk("byp_r9_n", n_rd2, 32'h0);
    tick();
    bus = '0;
    #1;
    chk("byp_r9_next_n", n_rd2, 32'hDEAD_BEEF);

    // HI from lane 1, LO from lane 2
    bus = {lane(1'b0, 1'b1, 32'h0, 32'h6, 1'b0, 5'd0, 32'h0),
           lane(1'b1, 1'b0, 32'h5, 32'h0, 1'b0, 5'd0, 32'h0)};
    #1;
    chk("hl_byp_hi_b", b_hi, 32'h5);
    chk("hl_byp_lo_b", b_lo, 32'h6);
    chk("hl_old_hi_n", n_hi, 32'h0);
    tick();
    bus = '0;
    #1;
    chk("hl_hi_n", n_hi, 32'h5);
    chk("hl_lo_n", n_lo, 32'h6);
    chk("hl_hi_b", b_hi, 32'h5);

    // both lanes write HI: lane 2 wins
    bus = {lane(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 5'd0, 32'h0),
           lane(1'b1, 1'b0, 32'h7, 32'h0, 1'b0, 5'd0, 32'h0)};
    #1;
    chk("hh_byp_hi_b", b_hi, 32'h8);
    tick();
    bus = '0;
    #1;
    chk("hh_hi_n", n_hi, 32'h8);
    chk("hh_lo_n", n_lo, 32'h6);
    chk("hh_hi_b", b_hi, 32'h8);

    // stalled bus leaves state untouched
    ra1 = 5'd3; ra2 = 5'd9;
    tick();
    chk("idle_r3_n", n_rd1, 32'h11);
    chk("idle_r9_b", b_rd2, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
